// File: rtl/periph_pkg.sv
// Shared definitions for the peripheral bus controller: register map,
// status/control bit positions, key-event record and digit register layout.
package periph_pkg;

  // Keypad scan code width and the event record returned by KEY_DATA.
  localparam int KEY_CODE_W = 4;

  typedef struct packed {
    logic                  valid;
    logic [KEY_CODE_W-1:0] code;
  } key_event_t;

  localparam int KEY_EVT_W = $bits(key_event_t);

  // Register addresses (word addresses).
  localparam int ADDR_KEY_DATA = 0;
  localparam int ADDR_KEY_STAT = 1;
  localparam int ADDR_KEY_CTRL = 2;

  // KEY_STAT field positions.
  localparam int STAT_OVF_BIT   = 7;
  localparam int STAT_FULL_BIT  = 6;
  localparam int STAT_EMPTY_BIT = 5;
  localparam int STAT_CNT_W     = 4;

  // KEY_CTRL field positions.
  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT  = 2;

  // Digit register layout: [3:0] value, [4] dot, [5] blank.
  localparam int DIG_VAL_W     = 4;
  localparam int DIG_DOT_BIT   = 4;
  localparam int DIG_BLANK_BIT = 5;
  localparam int DIG_W         = 6;

  // Clamp a FIFO occupancy into the status count field.
  function automatic logic [STAT_CNT_W-1:0] sat_count(input int unsigned c);
    int unsigned lim;
    lim = (1 << STAT_CNT_W) - 1;
    if (c > lim) return '1;
    else         return STAT_CNT_W'(c);
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Keypad event FIFO: circular buffer with push/pop/flush, occupancy count
// and a sticky overflow flag raised when a push is dropped while full.
module key_event_fifo
  import periph_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic                       i_clr_ovf,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Flush dominates everything in its cycle; a push into a full FIFO only
  // lands when a pop frees the head slot on the same edge.
  assign w_do_pop  = i_pop & ~w_empty & ~i_flush;
  assign w_do_push = i_push & ~i_flush & (~w_full | w_do_pop);

  // Storage array: written at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy; pointer wrap is free since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: a fresh drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (i_push & w_full & ~w_do_pop & ~i_flush) begin
      r_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_data     = r_mem[r_rd_ptr];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/peripheral_bus_controller.sv
// Memory-mapped bridge between the CPU data bus and the keypad / 7-seg
// peripherals. Bus protocol: address/din/strobes are sampled on the rising
// edge; a read strobe in cycle N returns registered data with dout_valid in
// cycle N+1. When both strobes are high the write wins and the read is dropped.
module peripheral_bus_controller
  import periph_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int NUM_DIGITS = 11,
  parameter int FIFO_DEPTH = 4,
  parameter int DISP_BASE  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       address,
  input  logic [DATA_W-1:0]       din,
  input  logic                    writeEnable,
  input  logic                    readEnable,
  output logic [DATA_W-1:0]       dout,
  output logic                    dout_valid,
  input  logic                    key_valid,
  input  logic [KEY_CODE_W-1:0]   key_code,
  output logic [NUM_DIGITS*4-1:0] disp_value,
  output logic [NUM_DIGITS-1:0]   disp_dot,
  output logic [NUM_DIGITS-1:0]   disp_blank,
  output logic                    irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DIG_W-1:0]      r_digit [NUM_DIGITS];
  logic [DATA_W-1:0]     r_dout;
  logic                  r_dout_valid;
  logic                  r_irq_en;

  logic                  w_rd;
  logic                  w_sel_data;
  logic                  w_sel_stat;
  logic                  w_sel_ctrl;
  logic                  w_wr_ctrl;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_clr_ovf;
  logic [KEY_CODE_W-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic                  w_overflow;
  logic [DATA_W-1:0]     w_rdata;
  key_event_t            w_head_evt;

  assign w_rd       = readEnable & ~writeEnable;
  assign w_sel_data = (address == ADDR_W'(ADDR_KEY_DATA));
  assign w_sel_stat = (address == ADDR_W'(ADDR_KEY_STAT));
  assign w_sel_ctrl = (address == ADDR_W'(ADDR_KEY_CTRL));
  assign w_wr_ctrl  = writeEnable & w_sel_ctrl;
  assign w_pop      = w_rd & w_sel_data;
  assign w_flush    = w_wr_ctrl & din[CTRL_FLUSH_BIT];
  assign w_clr_ovf  = w_wr_ctrl & din[CTRL_CLR_OVF_BIT];

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_CODE_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (key_valid),
    .i_data     (key_code),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .i_clr_ovf  (w_clr_ovf),
    .o_data     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_overflow (w_overflow)
  );

  assign w_head_evt.valid = 1'b1;
  assign w_head_evt.code  = w_head;

  // Interrupt enable lives in KEY_CTRL bit 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_en <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_irq_en <= din[CTRL_IRQ_EN_BIT];
    end
  end

  // Digit register file; reset leaves every digit blanked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_digit[i] <= DIG_W'(1 << DIG_BLANK_BIT);
      end
    end else if (writeEnable) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (address == ADDR_W'(DISP_BASE + i)) r_digit[i] <= din[DIG_W-1:0];
      end
    end
  end

  // Read mux over pre-edge state; unmapped addresses read zero.
  always_comb begin
    w_rdata = '0;
    if (w_sel_data) begin
      if (!w_empty) w_rdata[KEY_EVT_W-1:0] = w_head_evt;
    end else if (w_sel_stat) begin
      w_rdata[STAT_OVF_BIT]     = w_overflow;
      w_rdata[STAT_FULL_BIT]    = w_full;
      w_rdata[STAT_EMPTY_BIT]   = w_empty;
      w_rdata[STAT_CNT_W-1:0]   = sat_count(32'(w_count));
    end else if (w_sel_ctrl) begin
      w_rdata[CTRL_IRQ_EN_BIT]  = r_irq_en;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (address == ADDR_W'(DISP_BASE + i)) w_rdata[DIG_W-1:0] = r_digit[i];
      end
    end
  end

  // Registered read response; dout holds when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_rd;
      if (w_rd) r_dout <= w_rdata;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_disp
      assign disp_value[4*g +: 4] = r_digit[g][DIG_VAL_W-1:0];
      assign disp_dot[g]          = r_digit[g][DIG_DOT_BIT];
      assign disp_blank[g]        = r_digit[g][DIG_BLANK_BIT];
    end
  endgenerate

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign irq        = r_irq_en & ~w_empty;

endmodule

// File: tb/tb_peripheral_bus_controller.sv
// Bench for peripheral_bus_controller: directed vector table, hand-written
// reset/display sequences and a randomized run against a queue-based model.
module tb_peripheral_bus_controller;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 4;
  localparam int NUM_DIGITS = 11;
  localparam int FIFO_DEPTH = 4;
  localparam int DISP_BASE  = 4;

  logic                    clk;
  logic                    rst_n;
  logic [ADDR_W-1:0]       address;
  logic [DATA_W-1:0]       din;
  logic                    writeEnable;
  logic                    readEnable;
  logic [DATA_W-1:0]       dout;
  logic                    dout_valid;
  logic                    key_valid;
  logic [3:0]              key_code;
  logic [NUM_DIGITS*4-1:0] disp_value;
  logic [NUM_DIGITS-1:0]   disp_dot;
  logic [NUM_DIGITS-1:0]   disp_blank;
  logic                    irq;

  int n_cmp;
  int n_err;

  peripheral_bus_controller #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .NUM_DIGITS (NUM_DIGITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DISP_BASE  (DISP_BASE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .address     (address),
    .din         (din),
    .writeEnable (writeEnable),
    .readEnable  (readEnable),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .disp_value  (disp_value),
    .disp_dot    (disp_dot),
    .disp_blank  (disp_blank),
    .irq         (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    address = '0; din = '0; writeEnable = 1'b0; readEnable = 1'b0;
    key_valid = 1'b0; key_code = '0;
  endtask

  // Drive one cycle's inputs at the falling edge; return #1 after the rising edge.
  task automatic bus_cycle(input bit we, input bit re, input logic [3:0] a,
                           input logic [7:0] d, input bit kv, input logic [3:0] kc);
    @(negedge clk);
    address = a; din = d; writeEnable = we; readEnable = re;
    key_valid = kv; key_code = kc;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // directed vector table
  typedef struct {
    bit         we;
    bit         re;
    logic [3:0] addr;
    logic [7:0] din;
    bit         kv;
    logic [3:0] kc;
    bit         chk;
    logic [7:0] exp_dout;
    bit         exp_irq;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit we, bit re, logic [3:0] a, logic [7:0] d,
                              bit kv, logic [3:0] kc, bit chk, logic [7:0] e, bit ei);
    vec_t v;
    v.we = we; v.re = re; v.addr = a; v.din = d; v.kv = kv; v.kc = kc;
    v.chk = chk; v.exp_dout = e; v.exp_irq = ei;
    tbl.push_back(v);
  endfunction

  function automatic void wr(logic [3:0] a, logic [7:0] d, bit ei);
    add(1, 0, a, d, 0, 0, 0, 0, ei);
  endfunction
  function automatic void rd(logic [3:0] a, logic [7:0] e, bit ei);
    add(0, 1, a, 0, 0, 0, 1, e, ei);
  endfunction
  function automatic void key(logic [3:0] kc, bit ei);
    add(0, 0, 0, 0, 1, kc, 0, 0, ei);
  endfunction

  // behavioural model for the random run
  logic [3:0] mq[$];
  bit         m_ovf;
  bit         m_irq_en;
  logic [5:0] m_dig [NUM_DIGITS];
  logic [7:0] m_dout;

  function automatic void model_reset();
    mq.delete();
    m_ovf = 0; m_irq_en = 0; m_dout = 0;
    for (int i = 0; i < NUM_DIGITS; i++) m_dig[i] = 6'h20;
  endfunction

  function automatic logic [7:0] model_read(logic [3:0] a);
    int n;
    n = mq.size();
    if (a == 0) return (n > 0) ? (8'h10 + 8'(mq[0])) : 8'h00;
    if (a == 1) return 8'((m_ovf ? 128 : 0) + (n == FIFO_DEPTH ? 64 : 0) + (n == 0 ? 32 : 0) + n);
    if (a == 2) return m_irq_en ? 8'h04 : 8'h00;
    if (a >= DISP_BASE && a < DISP_BASE + NUM_DIGITS) return 8'(m_dig[a - DISP_BASE]);
    return 8'h00;
  endfunction

  function automatic void model_step(bit we, bit re, logic [3:0] a, logic [7:0] d,
                                     bit kv, logic [3:0] kc);
    bit rdv, pop, flush, was_full;
    rdv = re && !we;
    if (rdv) m_dout = model_read(a);
    pop      = rdv && a == 0 && mq.size() > 0;
    flush    = we && a == 2 && d[0];
    was_full = (mq.size() == FIFO_DEPTH);
    if (we && a == 2) begin
      if (d[1]) m_ovf = 0;
      m_irq_en = d[2];
    end
    if (we && a >= DISP_BASE && a < DISP_BASE + NUM_DIGITS) m_dig[a - DISP_BASE] = d[5:0];
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (kv) begin
        if (!was_full || pop) mq.push_back(kc);
        else m_ovf = 1;
      end
    end
  endfunction

  task automatic check_disp_model();
    logic [NUM_DIGITS*4-1:0] ev;
    logic [NUM_DIGITS-1:0]   ed, eb;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ev[4*i +: 4] = m_dig[i][3:0];
      ed[i] = m_dig[i][4];
      eb[i] = m_dig[i][5];
    end
    check("rnd_disp_value", 64'(disp_value), 64'(ev));
    check("rnd_disp_dot", 64'(disp_dot), 64'(ed));
    check("rnd_disp_blank", 64'(disp_blank), 64'(eb));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // reset state
    check("rst_dout", 64'(dout), 64'h0);
    check("rst_dout_valid", 64'(dout_valid), 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_disp_blank", 64'(disp_blank), 64'h7FF);
    check("rst_disp_value", 64'(disp_value), 64'h0);
    check("rst_disp_dot", 64'(disp_dot), 64'h0);

    // display outputs follow a write on the same edge
    bus_cycle(1, 0, 4'(DISP_BASE + 3), 8'h14, 0, 0);
    check("disp3_value", 64'(disp_value[15:12]), 64'h4);
    check("disp3_dot", 64'(disp_dot[3]), 64'h1);
    check("disp3_blank", 64'(disp_blank[3]), 64'h0);
    check("disp_other_blank", 64'(disp_blank), 64'h7F7);
    bus_cycle(0, 1, 4'(DISP_BASE + 3), 8'h00, 0, 0);
    check("disp3_rb_valid", 64'(dout_valid), 64'h1);
    check("disp3_rb", 64'(dout), 64'h14);
    bus_cycle(0, 0, 0, 0, 0, 0);
    check("idle_valid_low", 64'(dout_valid), 64'h0);
    check("idle_dout_hold", 64'(dout), 64'h14);

    // directed table
    rd(7, 8'h14, 0);
    key(4'h3, 0); key(4'hA, 0); key(4'h7, 0);
    rd(1, 8'h03, 0);
    rd(0, 8'h13, 0); rd(0, 8'h1A, 0); rd(0, 8'h17, 0); rd(0, 8'h00, 0);
    rd(1, 8'h20, 0);
    rd(3, 8'h00, 0); wr(15, 8'hFF, 0); rd(15, 8'h00, 0);
    wr(14, 8'hFF, 0); rd(14, 8'h3F, 0); rd(2, 8'h00, 0);
    key(4'h1, 0); key(4'h2, 0); key(4'h3, 0); key(4'h4, 0); key(4'h5, 0);
    rd(1, 8'hC4, 0);
    wr(2, 8'h02, 0);
    rd(1, 8'h44, 0);
    add(0, 1, 0, 0, 1, 4'h6, 1, 8'h11, 0);
    rd(1, 8'h44, 0);
    rd(0, 8'h12, 0); rd(0, 8'h13, 0); rd(0, 8'h14, 0); rd(0, 8'h16, 0);
    rd(1, 8'h20, 0);
    key(4'h8, 0);
    add(1, 0, 2, 8'h01, 1, 4'h9, 0, 0, 0);
    rd(1, 8'h20, 0);
    wr(2, 8'h04, 0);
    key(4'h5, 1);
    rd(1, 8'h01, 1);
    add(1, 1, 0, 8'h00, 0, 0, 0, 0, 1);
    rd(2, 8'h04, 1);
    rd(0, 8'h15, 0);
    rd(0, 8'h00, 0);

    foreach (tbl[k]) begin
      bus_cycle(tbl[k].we, tbl[k].re, tbl[k].addr, tbl[k].din, tbl[k].kv, tbl[k].kc);
      check($sformatf("vec%0d_valid", k), 64'(dout_valid), 64'(tbl[k].re && !tbl[k].we));
      if (tbl[k].chk) check($sformatf("vec%0d_dout", k), 64'(dout), 64'(tbl[k].exp_dout));
      check($sformatf("vec%0d_irq", k), 64'(irq), 64'(tbl[k].exp_irq));
    end

    // reset in the middle of activity with two keys queued
    bus_cycle(0, 0, 0, 0, 1, 4'h2);
    bus_cycle(1, 0, 4'(DISP_BASE), 8'h07, 1, 4'h9);
    bus_cycle(0, 1, 1, 0, 0, 0);
    check("pre_rst_stat", 64'(dout), 64'h02);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(dout_valid), 64'h0);
    check("async_rst_blank", 64'(disp_blank), 64'h7FF);
    check("async_rst_dout", 64'(dout), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_cycle(0, 1, 1, 0, 0, 0);
    check("post_rst_stat", 64'(dout), 64'h20);
    check("post_rst_valid", 64'(dout_valid), 64'h1);

    // randomized run against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 500; c++) begin
      bit we, re, kv;
      int op;
      logic [3:0] a, kc;
      logic [7:0] d;
      op = $urandom_range(0, 9);
      we = (op >= 5 && op <= 8);
      re = (op <= 4 || op == 8);
      a  = $urandom_range(0, 1) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      d  = 8'($urandom_range(0, 255));
      if (we && a == 2) d[0] = ($urandom_range(0, 7) == 0);
      kv = ($urandom_range(0, 2) == 0);
      kc = 4'($urandom_range(0, 15));
      bus_cycle(we, re, a, d, kv, kc);
      model_step(we, re, a, d, kv, kc);
      check("rnd_valid", 64'(dout_valid), 64'(re && !we));
      check("rnd_dout", 64'(dout), 64'(m_dout));
      check("rnd_irq", 64'(irq), 64'(m_irq_en && mq.size() > 0));
      check_disp_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
